// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer, empty flag and consumer stream for an async FIFO.
// Everything here runs in the rclk domain. The write pointer arrives already
// synchronized and Gray coded.
// Optional feature macro: FIFO_RD_OREG_EN adds a first-word-fall-through output
// register between the memory read port and the consumer. Without it, dout is the
// memory read data and dout_valid is simply !rempty.
module fifo_rd_ctrl #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   input  logic [DATASIZE-1:0] mem_rdata,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic [DATASIZE-1:0] dout,
   output logic                dout_valid,
   input  logic                dout_ready
);

   // Binary to Gray: g = (b >> 1) ^ b
   function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] bin);
      return {1'b0, bin[ADDRSIZE:1]} ^ bin;
   endfunction

   logic [ADDRSIZE:0]   rbin_r;
   logic [ADDRSIZE:0]   rptr_r;
   logic                rempty_r;
   logic [ADDRSIZE:0]   rbinnext_s;
   logic [ADDRSIZE:0]   rgraynext_s;
   logic                fetch_s;
   logic                valid_s;

`ifdef FIFO_RD_OREG_EN
   logic [DATASIZE-1:0] dout_r;
   logic                dout_valid_r;

   // Consumer view comes from the output register
   always_comb begin
      valid_s = dout_valid_r;
   end

   // Refill the output register whenever it is empty or being drained this cycle
   always_comb begin
      fetch_s = 1'b0;
      if (!rempty_r && (!dout_valid_r || dout_ready)) begin
         fetch_s = 1'b1;
      end else begin
         fetch_s = 1'b0;
      end
   end

   // Output register: load on fetch, drop valid on a consume with nothing behind it
   always_ff @(posedge rclk) begin
      if (rrst) begin
         dout_r       <= {DATASIZE{1'b0}};
         dout_valid_r <= 1'b0;
      end else if (fetch_s) begin
         dout_r       <= mem_rdata;
         dout_valid_r <= 1'b1;
      end else if (dout_valid_r && dout_ready) begin
         dout_r       <= dout_r;
         dout_valid_r <= 1'b0;
      end else begin
         dout_r       <= dout_r;
         dout_valid_r <= dout_valid_r;
      end
   end

   assign dout       = dout_r;
   assign dout_valid = dout_valid_r;
`else
   // Without the output register the memory word at raddr is presented directly;
   // it stays stable under backpressure because raddr only moves on a consume.
   always_comb begin
      valid_s = !rempty_r;
   end

   // Advance only when the consumer takes the word currently on dout
   always_comb begin
      fetch_s = 1'b0;
      if (valid_s && dout_ready) begin
         fetch_s = 1'b1;
      end else begin
         fetch_s = 1'b0;
      end
   end

   assign dout       = mem_rdata;
   assign dout_valid = valid_s;
`endif

   // Next pointer values (binary wraps naturally modulo 2^(ADDRSIZE+1))
   always_comb begin
      rbinnext_s  = rbin_r + {{ADDRSIZE{1'b0}}, fetch_s};
      rgraynext_s = bin2gray(rbinnext_s);
   end

   // Pointer and empty-flag registers; empty is a pure Gray equality test
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin_r   <= {(ADDRSIZE+1){1'b0}};
         rptr_r   <= {(ADDRSIZE+1){1'b0}};
         rempty_r <= 1'b1;
      end else begin
         rbin_r   <= rbinnext_s;
         rptr_r   <= rgraynext_s;
         rempty_r <= (rgraynext_s == rq2_wptr);
      end
   end

   assign raddr  = rbin_r[ADDRSIZE-1:0];
   assign rptr   = rptr_r;
   assign rempty = rempty_r;

endmodule
